cnt_arb_seq: RTL and testbench

Two-requester command sequencer for the 4-bit up/down/load counter. Accepts short counting commands from two clients, arbitrates round-robin, drives the counter's `en`/`dir`/`in`/`data` controls cycle by cycle, and returns the resulting count with a done pulse. It sits directly in front of the counter instance, so the counter becomes a shared, command-driven resource.

---
 rtl/cnt_arb_seq_pkg.sv | 23 ++
 rtl/cnt_arb_seq_rr_arb2.sv | 30 +++
 rtl/cnt_arb_seq.sv | 173 +++++++++++++++++
 tb/tb_cnt_arb_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cnt_arb_seq_pkg.sv
// Shared definitions for the two-requester counter command sequencer:
// op codes, FSM state encoding and the default counter width.
package cnt_arb_seq_pkg;

    localparam int CW_DEF = 4;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic is_step_op(input logic [1:0] op);
        return (op == OP_UP) || (op == OP_DOWN);
    endfunction

endpackage

// File: rtl/cnt_arb_seq_rr_arb2.sv
// Two-way round-robin arbiter with a last-grant pointer; one-hot grant is
// combinational and only issued while en is high.
module rr_arb2 (
    input  logic       clk,
    input  logic       srst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // last_reg = index of the most recent grant; reset to 1 so A is favoured.
    logic last_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt[gi] = en && req[gi] &&
                             (!req[1 - gi] || (last_reg != 1'(gi)));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            last_reg <= 1'b1;
        end else if (|gnt) begin
            last_reg <= gnt[1];
        end
    end

endmodule

// File: rtl/cnt_arb_seq.sv
// Round-robin command sequencer in front of a shared up/down/load counter.
// Optional self-check of the final count: define CNT_ARB_SEQ_CHECK_EN.
module cnt_arb_seq
    import cnt_arb_seq_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          req_b,
    input  logic [CW+1:0] cmd_a,
    input  logic [CW+1:0] cmd_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          busy,
    output logic          done,
    output logic          done_id,
    output logic [CW-1:0] result,
    output logic          ctr_en,
    output logic          ctr_dir,
    output logic          ctr_in,
    output logic [CW-1:0] ctr_data,
    input  logic [CW-1:0] ctr_out,
    output logic          err
);

    state_t        state_reg;
    logic [1:0]    op_reg;
    logic          id_reg;
    logic [CW-1:0] step_reg;
    logic          ctr_en_reg, ctr_dir_reg, ctr_in_reg;
    logic [CW-1:0] ctr_data_reg;
    logic          done_reg, done_id_reg;
    logic [CW-1:0] result_reg;

    logic [1:0]    gnt;
    logic [CW+1:0] cmd_sel;
    logic [1:0]    op_sel;
    logic [CW-1:0] arg_sel;

    rr_arb2 u_arb (
        .clk  (clk),
        .srst (rst),
        .en   ((state_reg == S_IDLE) && !rst),
        .req  ({req_b, req_a}),
        .gnt  (gnt)
    );

    assign gnt_a   = gnt[0];
    assign gnt_b   = gnt[1];
    assign cmd_sel = gnt[1] ? cmd_b : cmd_a;
    assign op_sel  = cmd_sel[CW+1:CW];
    assign arg_sel = cmd_sel[CW-1:0];

    // Controls are loaded at the grant edge so the first RUN cycle already
    // drives the counter; step_reg counts the enable cycles still to come.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            op_reg       <= OP_NOP;
            id_reg       <= 1'b0;
            step_reg     <= '0;
            ctr_en_reg   <= 1'b0;
            ctr_dir_reg  <= 1'b0;
            ctr_in_reg   <= 1'b0;
            ctr_data_reg <= '0;
            done_reg     <= 1'b0;
            done_id_reg  <= 1'b0;
            result_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (|gnt) begin
                        op_reg    <= op_sel;
                        id_reg    <= gnt[1];
                        step_reg  <= '0;
                        state_reg <= S_RUN;
                        if (op_sel == OP_LOAD) begin
                            ctr_en_reg   <= 1'b1;
                            ctr_in_reg   <= 1'b1;
                            ctr_data_reg <= arg_sel;
                        end else if (is_step_op(op_sel) && (arg_sel != '0)) begin
                            ctr_en_reg  <= 1'b1;
                            ctr_dir_reg <= (op_sel == OP_UP);
                            step_reg    <= arg_sel - 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (ctr_en_reg && (step_reg != '0)) begin
                        step_reg <= step_reg - 1'b1;
                    end else begin
                        ctr_en_reg   <= 1'b0;
                        ctr_dir_reg  <= 1'b0;
                        ctr_in_reg   <= 1'b0;
                        ctr_data_reg <= '0;
                        // Counting ops keep one trailing RUN cycle with the
                        // enable dropped before settling.
                        if (!(ctr_en_reg && is_step_op(op_reg))) begin
                            state_reg <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    // Counter is quiet here, so sampling now presents the
                    // final count during the DONE cycle.
                    done_reg    <= 1'b1;
                    done_id_reg <= id_reg;
                    result_reg  <= ctr_out;
                    state_reg   <= S_DONE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_reg != S_IDLE);
    assign done     = done_reg;
    assign done_id  = done_id_reg;
    assign result   = result_reg;
    assign ctr_en   = ctr_en_reg;
    assign ctr_dir  = ctr_dir_reg;
    assign ctr_in   = ctr_in_reg;
    assign ctr_data = ctr_data_reg;

`ifdef CNT_ARB_SEQ_CHECK_EN
    logic [CW-1:0] arg_reg;
    logic [CW-1:0] start_reg;
    logic          first_reg;
    logic          err_reg;
    logic [CW-1:0] expect_val;

    always_comb begin
        expect_val = start_reg;
        case (op_reg)
            OP_LOAD: expect_val = arg_reg;
            OP_UP:   expect_val = start_reg + arg_reg;
            OP_DOWN: expect_val = start_reg - arg_reg;
            default: expect_val = start_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arg_reg   <= '0;
            start_reg <= '0;
            first_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            if ((state_reg == S_IDLE) && (|gnt)) begin
                arg_reg   <= arg_sel;
                first_reg <= 1'b1;
            end
            if ((state_reg == S_RUN) && first_reg) begin
                start_reg <= ctr_out;
                first_reg <= 1'b0;
            end
            if ((state_reg == S_DONE) && (ctr_out != expect_val)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_arb_seq.sv
// Randomized self-checking bench for cnt_arb_seq with a behavioural counter
// and a command-level reference model (final value, latency, arbitration).
module tb_cnt_arb_seq;

    localparam logic [1:0] LOAD = 2'b00, UP = 2'b01, DOWN = 2'b10, NOP = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [5:0] cmd_a = '0, cmd_b = '0;
    logic       gnt_a, gnt_b, busy, done, done_id;
    logic [3:0] result;
    logic       ctr_en, ctr_dir, ctr_in;
    logic [3:0] ctr_data;
    logic [3:0] ctr = 4'd0;
    logic       err;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  last_id = 1;        // reference pointer: reset favours A
    logic [3:0] cur = 4'd0;  // reference counter value
    int  err_model = 0;
    bit  skip_arm = 1'b0;
    bit  skip_used = 1'b0;

    cnt_arb_seq #(.CW(4)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy),
        .done(done), .done_id(done_id), .result(result),
        .ctr_en(ctr_en), .ctr_dir(ctr_dir), .ctr_in(ctr_in),
        .ctr_data(ctr_data), .ctr_out(ctr), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Counter under control; can be told to swallow one counting step.
    always @(posedge clk) begin
        if (ctr_en) begin
            if (!ctr_in && skip_arm && !skip_used) skip_used <= 1'b1;
            else if (ctr_in) ctr <= ctr_data;
            else if (ctr_dir) ctr <= ctr + 4'd1;
            else ctr <= ctr - 4'd1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic issue(input bit ra, input bit rb, input logic [5:0] ca,
                         input logic [5:0] cb, input bit skip);
        int win, g, ens, ens_exp, lat_exp;
        bit got;
        logic [5:0] c;
        logic [1:0] op;
        logic [3:0] arg, exp_res;
        req_a = ra; cmd_a = ca; req_b = rb; cmd_b = cb;
        win = (ra && rb) ? (last_id == 1 ? 0 : 1) : (rb ? 1 : 0);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (gnt_a || gnt_b) got = 1'b1;
        end
        if (!got) begin
            check("gnt_timeout", 0, 1);
            req_a = 1'b0; req_b = 1'b0;
            return;
        end
        check("gnt_a", int'(gnt_a), int'(win == 0));
        check("gnt_b", int'(gnt_b), int'(win == 1));
        check("err", int'(err), err_model);
        g = cyc;
        last_id = win;
        c = (win == 1) ? cb : ca;
        op = c[5:4];
        arg = c[3:0];
        exp_res = cur; ens_exp = 0; lat_exp = 3;
        case (op)
            LOAD: begin exp_res = arg; ens_exp = 1; end
            UP:   begin exp_res = cur + arg; ens_exp = arg; lat_exp = (arg == 0) ? 3 : arg + 3; end
            DOWN: begin exp_res = cur - arg; ens_exp = arg; lat_exp = (arg == 0) ? 3 : arg + 3; end
            default: ;
        endcase
        if (skip && op == UP && arg != 0) exp_res = exp_res - 4'd1;
        if (skip && op == DOWN && arg != 0) exp_res = exp_res + 4'd1;
        cur = exp_res;
        @(posedge clk);
        #1;
        if (win == 0) req_a = 1'b0; else req_b = 1'b0;
        ens = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            check("busy", int'(busy), 1);
            check("no_gnt_busy", int'(gnt_a | gnt_b), 0);
            if (ctr_en) begin
                ens++;
                check("ctr_in", int'(ctr_in), int'(op == LOAD));
                if (op == LOAD) check("ctr_data", int'(ctr_data), int'(arg));
                else check("ctr_dir", int'(ctr_dir), int'(op == UP));
            end else begin
                check("ctrl_low", int'({ctr_in, ctr_dir, ctr_data}), 0);
            end
            if (done) got = 1'b1;
        end
        if (!got) begin
            check("done_timeout", 0, 1);
            return;
        end
        check("latency", cyc - g, lat_exp);
        check("en_cycles", ens, ens_exp);
        check("result", int'(result), int'(exp_res));
        check("done_id", int'(done_id), win);
        $display("[TB] cmd id=%0d op=%0d arg=%0d result=%0d latency=%0d",
                 win, op, arg, result, cyc - g);
    endtask

    initial begin
        logic [5:0] ca, cb;
        int pat;
        bit got;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ctrl", int'({ctr_en, ctr_dir, ctr_in, ctr_data}), 0);
        check("rst_result", int'(result), 0);
        check("rst_err", int'(err), 0);
        rst = 1'b0;

        // Directed: load, count up, wrap down, longest count.
        issue(1, 0, {LOAD, 4'b1010}, 6'd0, 0);
        issue(0, 1, 6'd0, {UP, 4'd3}, 0);
        issue(1, 0, {LOAD, 4'b0001}, 6'd0, 0);
        issue(0, 1, 6'd0, {DOWN, 4'd3}, 0);
        issue(1, 0, {UP, 4'd15}, 6'd0, 0);
        issue(0, 1, 6'd0, {DOWN, 4'd0}, 0);

        // Both held with NOPs: grants must alternate.
        for (int i = 0; i < 4; i++) issue(1, 1, {NOP, 4'd0}, {NOP, 4'd0}, 0);

        // Randomized mix; a losing requester keeps its request until served.
        for (int i = 0; i < 30; i++) begin
            ca = 6'($urandom);
            cb = 6'($urandom);
            pat = $urandom_range(0, 2);
            if (pat == 0) issue(1, 0, ca, cb, 0);
            else if (pat == 1) issue(0, 1, ca, cb, 0);
            else begin
                issue(1, 1, ca, cb, 0);
                issue(last_id == 1, last_id == 0, ca, cb, 0);
            end
        end

        // Reset in the middle of UP 10.
        req_a = 1'b1; cmd_a = {UP, 4'd10};
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (gnt_a) got = 1'b1;
        end
        check("abort_gnt", int'(got), 1);
        @(posedge clk);
        #1 req_a = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ctrl", int'({ctr_en, ctr_dir, ctr_in, ctr_data}), 0);
        check("abort_busy", int'(busy), 0);
        rst = 1'b0;
        last_id = 1;
        err_model = 0;
        got = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check("abort_no_done", int'(got), 0);
        issue(0, 1, 6'd0, {LOAD, 4'b0110}, 0);
        issue(1, 0, {UP, 4'd2}, 6'd0, 0);

`ifdef CNT_ARB_SEQ_CHECK_EN
        // Counter swallows one step: err must rise and stick until reset.
        skip_arm = 1'b1;
        issue(1, 0, {UP, 4'd3}, 6'd0, 1);
        err_model = 1;
        issue(0, 1, 6'd0, {LOAD, 4'd5}, 0);
        issue(1, 0, {NOP, 4'd0}, 6'd0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_id = 1;
        err_model = 0;
        check("err_cleared", int'(err), 0);
        issue(1, 0, {LOAD, 4'd9}, 6'd0, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        check("err_final", int'(err), err_model);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
